// File: rtl/lc3b_fetch_unit_pkg.sv
// Shared types for the LC-3b instruction-fetch front end.
//   lc3b_word         16-bit machine word / address
//   lc3b_fetch_state  fetch FSM state (idle, read outstanding, read being discarded)
//   lc3b_fetch_entry  one buffered fetch: instruction word plus the address it came from
package lc3b_fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } lc3b_fetch_state;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
  } lc3b_fetch_entry;

  // Instruction addresses are word aligned; bit 0 is always dropped.
  function automatic lc3b_word lc3b_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

  // Sequential next address, wrapping modulo 2^16.
  function automatic lc3b_word lc3b_next_pc(input lc3b_word addr);
    return addr + 16'd2;
  endfunction

endpackage

// File: rtl/lc3b_fetch_unit_fifo.sv
// fetch_fifo: small instruction buffer between the fetch FSM and decode.
//   clk, reset   clock / asynchronous active-high reset
//   flush        empties the buffer; wins over push and pop in the same cycle
//   push, din    write one entry at the tail (caller guarantees space)
//   pop          remove the head entry (caller guarantees non-empty)
//   dout         registered head entry
//   empty, count occupancy status
module lc3b_fetch_unit_fifo
  import lc3b_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  lc3b_fetch_entry din,
  output lc3b_fetch_entry dout,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lc3b_fetch_entry mem_q [DEPTH];
  lc3b_fetch_entry mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        // DEPTH is a power of two, so the natural pointer overflow is the wrap.
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction-fetch front end. Owns the fetch PC, runs the single-outstanding
// instruction-memory read handshake, buffers fetched words and presents them to decode
// under a valid/ready handshake. A datapath redirect flushes the buffer and restarts fetch.
//   clk, reset          clock / asynchronous active-high reset
//   redirect,
//   redirect_pc         non-sequential PC taken by the datapath this cycle
//   instr, instr_pc,
//   instr_valid,
//   instr_ready         decode handshake on the buffer head
//   imem_address,
//   imem_read           read request, held until imem_resp
//   imem_rdata,
//   imem_resp           read data and its one-cycle completion pulse
module lc3b_fetch_unit
  import lc3b_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter lc3b_word    RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output lc3b_word instr,
  output lc3b_word instr_pc,
  output logic     instr_valid,
  input  logic     instr_ready,
  output lc3b_word imem_address,
  output logic     imem_read,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        fetch_pc_q, fetch_pc_d;
  lc3b_word        req_addr_q, req_addr_d;

  logic            buf_push;
  logic            buf_pop;
  logic            buf_empty;
  logic [CntW-1:0] buf_count;
  logic [CntW-1:0] count_after;
  lc3b_fetch_entry buf_din;
  lc3b_fetch_entry buf_head;

  // A redirect kills any pop in the same cycle; the flush wins inside the buffer too.
  assign buf_pop     = instr_valid && instr_ready && !redirect;
  assign buf_din     = '{instr: imem_rdata, pc: req_addr_q};
  // Occupancy as it will be after this edge, used to decide on a back-to-back request.
  assign count_after = buf_count + CntW'(buf_push) - CntW'(buf_pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    buf_push   = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (redirect) begin
          fetch_pc_d = lc3b_align(redirect_pc);
        end else if (buf_count < CntW'(DEPTH)) begin
          state_d    = FETCH_REQ;
          req_addr_d = fetch_pc_q;
        end
      end

      FETCH_REQ: begin
        if (redirect) begin
          fetch_pc_d = lc3b_align(redirect_pc);
          // The read cannot be cancelled: if it has not completed, wait it out and drop it.
          state_d    = imem_resp ? FETCH_IDLE : FETCH_DISCARD;
        end else if (imem_resp) begin
          buf_push   = 1'b1;
          fetch_pc_d = lc3b_next_pc(fetch_pc_q);
          if (count_after < CntW'(DEPTH)) begin
            state_d    = FETCH_REQ;
            req_addr_d = lc3b_next_pc(fetch_pc_q);
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end

      FETCH_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = lc3b_align(redirect_pc);
        end
        if (imem_resp) begin
          state_d = FETCH_IDLE;
        end
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  lc3b_fetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (buf_din),
    .dout  (buf_head),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign imem_read    = (state_q != FETCH_IDLE);
  assign imem_address = req_addr_q;
  assign instr_valid  = !buf_empty;
  assign instr        = buf_head.instr;
  assign instr_pc     = buf_head.pc;

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Bench for lc3b_fetch_unit: a cycle table for the basic fetch / back-pressure timing,
// hand sequences for redirect, wrap and reset corners, and a long random run whose
// pops are scored against the rule "decode sees consecutive words from the last
// redirect target (or RESET_PC), each carrying the memory contents at its address".
module tb_lc3b_fetch_unit;
  import lc3b_fetch_unit_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam lc3b_word    RESET_PC = 16'h0000;

  logic     clk = 1'b0;
  logic     reset = 1'b0;
  logic     redirect;
  lc3b_word redirect_pc;
  lc3b_word instr;
  lc3b_word instr_pc;
  logic     instr_valid;
  logic     instr_ready;
  lc3b_word imem_address;
  logic     imem_read;
  lc3b_word imem_rdata;
  logic     imem_resp;

  always #5 clk = ~clk;

  lc3b_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory model state
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          busy = 1'b0;
  int unsigned cnt = 0;
  lc3b_word    mem_addr = '0;

  // Reference stream state
  lc3b_word    exp_pc = RESET_PC;
  int unsigned pops = 0;

  function automatic lc3b_word mem_word(input lc3b_word a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic check16(input string name, input lc3b_word act, input lc3b_word req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: score the pre-edge handshake, then update the memory model after the edge.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      exp_pc = RESET_PC;
    end else if (redirect) begin
      exp_pc = {redirect_pc[15:1], 1'b0};
    end else if (instr_valid && instr_ready) begin
      check16("pop_pc", instr_pc, exp_pc);
      check16("pop_instr", instr, mem_word(exp_pc));
      exp_pc = exp_pc + 16'd2;
      pops++;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      busy      = 1'b0;
      imem_resp = 1'b0;
    end else begin
      if (imem_resp) begin
        imem_resp = 1'b0;
        busy      = 1'b0;
      end
      if (busy) begin
        check1("read_held", imem_read, 1'b1);
        check16("addr_stable", imem_address, mem_addr);
      end
      if (!busy && imem_read) begin
        busy     = 1'b1;
        mem_addr = imem_address;
        cnt      = $urandom_range(lat_max, lat_min);
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(mem_addr);
        end
      end
      if (!imem_resp) imem_rdata = lc3b_word'($urandom);
    end
  endtask

  // A response with no read outstanding would be a bench (memory model) bug.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_resp && !imem_read))
      else begin
        miscompares++;
        $display("FAIL resp_while_idle: imem_resp=1 with imem_read=%b", imem_read);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       rst;
    bit       ready;
    bit       exp_read;
    lc3b_word exp_addr;
    bit       exp_valid;
    lc3b_word exp_pc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit saw_valid;
    bit found;

    // Reset, 1-cycle memory, ready=1: sequential fetch 0000, 0002, 0004 ...
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004};
    // Reset with ready=0: two reads fill the buffer, fetch stalls, resumes at 0004.
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004};

    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_resp   = 1'b0;
    imem_rdata  = '0;

    // Reset values, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check1("rst_imem_read", imem_read, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check16("rst_instr", instr, 16'h0000);
    check16("rst_instr_pc", instr_pc, 16'h0000);
    @(posedge clk);
    #1;

    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 13; i++) begin
      reset       = tbl[i].rst;
      instr_ready = tbl[i].ready;
      redirect    = 1'b0;
      tick();
      check1($sformatf("tbl%0d_read", i), imem_read, tbl[i].exp_read);
      if (tbl[i].exp_read) check16($sformatf("tbl%0d_addr", i), imem_address, tbl[i].exp_addr);
      check1($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check16($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
        check16($sformatf("tbl%0d_instr", i), instr, mem_word(tbl[i].exp_pc));
      end
    end

    // Redirect to 3001 while a 3-cycle read is outstanding: its data must never appear.
    reset = 1'b1; instr_ready = 1'b0; tick();
    reset = 1'b0; lat_min = 3; lat_max = 3; tick();
    check1("t3_read", imem_read, 1'b1);
    check16("t3_addr", imem_address, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h3001; tick();
    redirect = 1'b0; lat_min = 1; lat_max = 1;
    check1("t3_discard_read", imem_read, 1'b1);
    check16("t3_discard_addr", imem_address, 16'h0000);
    saw_valid = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_read && imem_address == 16'h3000) found = 1'b1;
      else saw_valid = saw_valid | instr_valid;
    end
    check1("t3_refetch_3000", found, 1'b1);
    check1("t3_no_stale_valid", saw_valid | instr_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    check1("t3_valid_after", found, 1'b1);
    check16("t3_pc", instr_pc, 16'h3000);
    check16("t3_instr", instr, mem_word(16'h3000));
    instr_ready = 1'b1; tick();

    // Redirect and response in the same cycle: data dropped, next read at the target.
    reset = 1'b1; instr_ready = 1'b0; tick();
    reset = 1'b0; tick();
    check1("t4_read", imem_read, 1'b1);
    redirect = 1'b1; redirect_pc = 16'h1235; tick();
    redirect = 1'b0;
    check1("t4_idle", imem_read, 1'b0);
    check1("t4_empty", instr_valid, 1'b0);
    tick();
    check1("t4_req", imem_read, 1'b1);
    check16("t4_addr", imem_address, 16'h1234);
    check1("t4_still_empty", instr_valid, 1'b0);
    tick();
    check1("t4_valid", instr_valid, 1'b1);
    check16("t4_pc", instr_pc, 16'h1234);

    // Wrap FFFE -> 0000 with push and pop in the same cycle keeping one entry buffered.
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFF; tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = instr_valid;
    end
    check1("t5_valid", found, 1'b1);
    check16("t5_pc_fffe", instr_pc, 16'hFFFE);
    tick();
    check1("t5_steady0", instr_valid, 1'b1);
    check16("t5_pc_0000", instr_pc, 16'h0000);
    tick();
    check1("t5_steady1", instr_valid, 1'b1);
    check16("t5_pc_0002", instr_pc, 16'h0002);

    // Reset asserted mid-read drops imem_read and instr_valid before the next edge.
    reset = 1'b1; instr_ready = 1'b0; tick();
    reset = 1'b0; tick(); tick();
    check1("t6_pre_read", imem_read, 1'b1);
    check1("t6_pre_valid", instr_valid, 1'b1);
    reset = 1'b1;
    #1;
    check1("t6_async_read", imem_read, 1'b0);
    check1("t6_async_valid", instr_valid, 1'b0);
    tick();
    reset = 1'b0; tick();
    check1("t6_refetch_read", imem_read, 1'b1);
    check16("t6_refetch_addr", imem_address, RESET_PC);

    // Random traffic scored against the sequential-stream reference.
    reset = 1'b1; tick();
    reset = 1'b0;
    lat_min = 1; lat_max = 4;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(9, 0) < 7);
      redirect    = ($urandom_range(31, 0) == 0);
      redirect_pc = lc3b_word'($urandom);
      tick();
    end
    redirect = 1'b0;
    check1("rand_liveness", pops >= 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
